// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : whack_pkg
//  Description : Shared types, hex segment table and decode helper for the
//                whack-a-mole display-bus monitor.
//  Revision    : 1.0
// ============================================================================
package whack_pkg;

    // Game tracking state
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Classification of a committed {dp,seg} pattern
    typedef enum logic [1:0] {
        MOLE    = 2'd0,
        BLANK   = 2'd1,
        DIGIT   = 2'd2,
        INVALID = 2'd3
    } pat_class_t;

    // Active-low segment encodings for hex digits 0..F (bit n = segment n)
    localparam logic [6:0] SEG7_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reverse lookup: returns {hit, digit}; hit=0 when seg is not a hex glyph
    function automatic logic [4:0] seg7_to_hex(input logic [6:0] seg);
        logic       hit;
        logic [3:0] dig;
        hit = 1'b0;
        dig = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && (seg == SEG7_HEX[i])) begin
                hit = 1'b1;
                dig = 4'(i);
            end
        end
        return {hit, dig};
    endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/seg7_stable_filter.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_stable_filter
//  Description : Deglitch filter. A word must be sampled STABLE_CYCLES times
//                in a row, and differ from the last committed word, before a
//                single-cycle commit is issued.
//  Revision    : 1.0
// ============================================================================
module seg7_stable_filter #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_commit,
    output logic [WIDTH-1:0] o_word
);

    localparam int             CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_s0;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_have;

    logic             w_same;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_commit;

    // Run-length count of the sample being registered versus the previous one
    always_comb begin
        w_same     = (i_data == r_s0);
        w_cnt_next = '0;
        if (w_same) begin
            w_cnt_next = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;
        end
        // Commit only when the run length lands exactly on the threshold, so a
        // long-held pattern commits once; repeats of the committed word are dropped.
        w_commit = i_ena && (w_cnt_next == c_CNT_LAST) &&
                   (!r_have || (i_data != r_word));
    end

    // Sample register, run counter and last-committed word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0   <= '0;
            r_cnt  <= '0;
            r_word <= '0;
            r_have <= 1'b0;
        end else if (i_ena) begin
            r_s0  <= i_data;
            r_cnt <= w_cnt_next;
            if (w_commit) begin
                r_word <= i_data;
                r_have <= 1'b1;
            end
        end
    end

    // The word being committed this cycle (meaningful while o_commit is high)
    assign o_commit = w_commit;
    assign o_word   = i_data;

endmodule : seg7_stable_filter
`default_nettype wire

// File: rtl/seg7_game_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_game_monitor
//  Description : Receive-side decoder for the whack-a-mole display bus.
//                Deglitches {dp,seg}, classifies mole/blank/digit/invalid,
//                tracks SYNC/PLAY/OVER, keeps a high score and error flags.
//  Revision    : 1.0
// ============================================================================
module seg7_game_monitor
    import whack_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [7:0] score_in,
    output logic       mole_valid,
    output logic [2:0] mole_pos,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       game_over,
    output logic       over_pulse,
    output logic [7:0] moles_seen,
    output logic [7:0] high_score,
    output logic       new_record,
    output logic       pattern_err,
    output logic       mismatch
);

    logic       w_commit;
    logic [7:0] w_word;
    logic       w_dp;
    logic [6:0] w_seg;
    logic [2:0] w_zero_cnt;
    logic [2:0] w_zero_idx;
    logic [4:0] w_hex;
    pat_class_t w_class;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_mole_v;
    logic       w_digit_v;
    logic       w_over_v;
    logic       w_err_v;

    logic       r_mole_valid;
    logic [2:0] r_mole_pos;
    logic       r_digit_valid;
    logic [3:0] r_digit;
    logic       r_over_pulse;
    logic [7:0] r_moles_seen;
    logic [7:0] r_high_score;
    logic       r_new_record;
    logic       r_pattern_err;
    logic       r_mismatch;

    seg7_stable_filter #(
        .WIDTH         (8),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .i_ena    (ena),
        .i_data   ({dp_in, seg_in}),
        .o_commit (w_commit),
        .o_word   (w_word)
    );

    assign w_dp  = w_word[7];
    assign w_seg = w_word[6:0];
    assign w_hex = seg7_to_hex(w_seg);

    // Count lit (low) segments and remember the index of the lit one
    always_comb begin
        w_zero_cnt = 3'd0;
        w_zero_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!w_seg[i]) begin
                w_zero_cnt = w_zero_cnt + 3'd1;
                w_zero_idx = 3'(i);
            end
        end
    end

    // Classify the word under commit
    always_comb begin
        w_class = INVALID;
        if (w_dp && (w_zero_cnt == 3'd1)) begin
            w_class = MOLE;
        end else if (w_dp && (w_seg == 7'h7F)) begin
            w_class = BLANK;
        end else if (!w_dp && w_hex[4]) begin
            w_class = DIGIT;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Next state and event strobes from the committed pattern class
    always_comb begin
        w_state_next = r_state;
        w_mole_v     = 1'b0;
        w_digit_v    = 1'b0;
        w_over_v     = 1'b0;
        w_err_v      = 1'b0;
        if (w_commit) begin
            case (w_class)
                MOLE: begin
                    w_state_next = PLAY;
                    w_mole_v     = 1'b1;
                end
                DIGIT: begin
                    w_digit_v = 1'b1;
                    if (r_state != OVER) begin
                        w_state_next = OVER;
                        w_over_v     = 1'b1;
                    end
                end
                INVALID: w_err_v = 1'b1;
                default: ;
            endcase
        end
    end

    // Held outputs, counters, score tracking and one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mole_valid  <= 1'b0;
            r_mole_pos    <= 3'd0;
            r_digit_valid <= 1'b0;
            r_digit       <= 4'd0;
            r_over_pulse  <= 1'b0;
            r_moles_seen  <= 8'd0;
            r_high_score  <= 8'd0;
            r_new_record  <= 1'b0;
            r_pattern_err <= 1'b0;
            r_mismatch    <= 1'b0;
        end else begin
            r_mole_valid  <= 1'b0;
            r_digit_valid <= 1'b0;
            r_over_pulse  <= 1'b0;
            r_new_record  <= 1'b0;
            if (ena) begin
                r_mole_valid  <= w_mole_v;
                r_digit_valid <= w_digit_v;
                r_over_pulse  <= w_over_v;
                if (w_mole_v) begin
                    r_mole_pos   <= w_zero_idx;
                    r_moles_seen <= (r_state == PLAY) ? r_moles_seen + 8'd1 : 8'd1;
                end
                if (w_digit_v) begin
                    r_digit <= w_hex[3:0];
                end
                if (w_over_v) begin
                    if (score_in > r_high_score) begin
                        r_high_score <= score_in;
                        r_new_record <= 1'b1;
                    end
                    if (score_in[3:0] != w_hex[3:0]) begin
                        r_mismatch <= 1'b1;
                    end
                end
                if (w_err_v) begin
                    r_pattern_err <= 1'b1;
                end
            end
        end
    end

    assign mole_valid  = r_mole_valid;
    assign mole_pos    = r_mole_pos;
    assign digit_valid = r_digit_valid;
    assign digit       = r_digit;
    assign game_over   = (r_state == OVER);
    assign over_pulse  = r_over_pulse;
    assign moles_seen  = r_moles_seen;
    assign high_score  = r_high_score;
    assign new_record  = r_new_record;
    assign pattern_err = r_pattern_err;
    assign mismatch    = r_mismatch;

endmodule : seg7_game_monitor
`default_nettype wire

// File: tb/tb_seg7_game_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_game_monitor
//  Description : Directed, table-driven self-checking bench for
//                seg7_game_monitor.
//  Revision    : 1.0
// ============================================================================
module tb_seg7_game_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [7:0] score_in;
    logic       mole_valid;
    logic [2:0] mole_pos;
    logic       digit_valid;
    logic [3:0] digit;
    logic       game_over;
    logic       over_pulse;
    logic [7:0] moles_seen;
    logic [7:0] high_score;
    logic       new_record;
    logic       pattern_err;
    logic       mismatch;

    int n_cmp = 0;
    int n_bad = 0;
    int c_mv  = 0;
    int c_dv  = 0;
    int c_ov  = 0;
    int c_nr  = 0;

    always #5 clk = ~clk;

    seg7_game_monitor #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .score_in    (score_in),
        .mole_valid  (mole_valid),
        .mole_pos    (mole_pos),
        .digit_valid (digit_valid),
        .digit       (digit),
        .game_over   (game_over),
        .over_pulse  (over_pulse),
        .moles_seen  (moles_seen),
        .high_score  (high_score),
        .new_record  (new_record),
        .pattern_err (pattern_err),
        .mismatch    (mismatch)
    );

    typedef struct {
        logic [7:0] pat;
        logic [7:0] score;
        int n;
        int mv, dv, ov, nr;
        int pos, seen, dig, go, hs, perr, mism;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c_mv += int'(mole_valid);
        c_dv += int'(digit_valid);
        c_ov += int'(over_pulse);
        c_nr += int'(new_record);
    endtask

    task automatic clear_counts();
        c_mv = 0; c_dv = 0; c_ov = 0; c_nr = 0;
    endtask

    task automatic drive(input logic [7:0] pat, input logic [7:0] sc);
        dp_in    = pat[7];
        seg_in   = pat[6:0];
        score_in = sc;
    endtask

    initial begin
        //            pat    score n  mv dv ov nr pos seen dig go hs perr mism
        vt[0]  = '{8'hFF, 8'd0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{8'hF7, 8'd0, 4, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{8'hBF, 8'd0, 4, 1, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0};
        vt[3]  = '{8'hFE, 8'd0, 3, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0};
        vt[4]  = '{8'hBF, 8'd0, 4, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0};
        vt[5]  = '{8'hFF, 8'd0, 4, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0};
        vt[6]  = '{8'hBF, 8'd0, 4, 1, 0, 0, 0, 6, 3, 0, 0, 0, 0, 0};
        vt[7]  = '{8'h12, 8'd5, 4, 0, 1, 1, 1, 6, 3, 5, 1, 5, 0, 0};
        vt[8]  = '{8'hFE, 8'd5, 4, 1, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0};
        vt[9]  = '{8'h30, 8'd3, 4, 0, 1, 1, 0, 0, 1, 3, 1, 5, 0, 0};
        vt[10] = '{8'h9F, 8'd3, 4, 0, 0, 0, 0, 0, 1, 3, 1, 5, 1, 0};
        vt[11] = '{8'hEF, 8'd3, 4, 1, 0, 0, 0, 4, 1, 3, 0, 5, 1, 0};
        vt[12] = '{8'h78, 8'd9, 4, 0, 1, 1, 1, 4, 1, 7, 1, 9, 1, 1};
        vt[13] = '{8'h00, 8'd9, 4, 0, 1, 0, 0, 4, 1, 8, 1, 9, 1, 1};

        // Reset
        rst = 1'b1;
        ena = 1'b1;
        drive(8'hFF, 8'd0);
        tick();
        tick();
        check("reset mole_valid",  int'(mole_valid),  0);
        check("reset mole_pos",    int'(mole_pos),    0);
        check("reset digit_valid", int'(digit_valid), 0);
        check("reset digit",       int'(digit),       0);
        check("reset game_over",   int'(game_over),   0);
        check("reset over_pulse",  int'(over_pulse),  0);
        check("reset moles_seen",  int'(moles_seen),  0);
        check("reset high_score",  int'(high_score),  0);
        check("reset new_record",  int'(new_record),  0);
        check("reset pattern_err", int'(pattern_err), 0);
        check("reset mismatch",    int'(mismatch),    0);
        rst = 1'b0;

        // Table-driven sequence
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].pat, vt[i].score);
            clear_counts();
            repeat (vt[i].n) tick();
            check($sformatf("v%0d mole_valid pulses", i),  c_mv, vt[i].mv);
            check($sformatf("v%0d digit_valid pulses", i), c_dv, vt[i].dv);
            check($sformatf("v%0d over_pulse pulses", i),  c_ov, vt[i].ov);
            check($sformatf("v%0d new_record pulses", i),  c_nr, vt[i].nr);
            check($sformatf("v%0d mole_pos", i),    int'(mole_pos),    vt[i].pos);
            check($sformatf("v%0d moles_seen", i),  int'(moles_seen),  vt[i].seen);
            check($sformatf("v%0d digit", i),       int'(digit),       vt[i].dig);
            check($sformatf("v%0d game_over", i),   int'(game_over),   vt[i].go);
            check($sformatf("v%0d high_score", i),  int'(high_score),  vt[i].hs);
            check($sformatf("v%0d pattern_err", i), int'(pattern_err), vt[i].perr);
            check($sformatf("v%0d mismatch", i),    int'(mismatch),    vt[i].mism);
        end

        // ena=0 in the middle of a stable mole: count resumes, single pulse later
        drive(8'hDF, 8'd9);
        clear_counts();
        tick();
        tick();
        ena = 1'b0;
        tick();
        tick();
        tick();
        check("ena-off mole_valid pulses", c_mv, 0);
        check("ena-off game_over held",    int'(game_over), 1);
        ena = 1'b1;
        tick();
        check("ena-resume early pulse", c_mv, 0);
        tick();
        check("ena-resume mole_valid pulses", c_mv, 1);
        check("ena-resume mole_pos",   int'(mole_pos),   5);
        check("ena-resume moles_seen", int'(moles_seen), 1);
        check("ena-resume game_over",  int'(game_over),  0);
        check("ena-resume high_score", int'(high_score), 9);

        // Reset after two filter cycles discards the partial count
        drive(8'hFD, 8'd0);
        clear_counts();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst mole_valid pulses", c_mv, 0);
        check("midrst moles_seen",  int'(moles_seen),  0);
        check("midrst high_score",  int'(high_score),  0);
        check("midrst pattern_err", int'(pattern_err), 0);
        check("midrst mismatch",    int'(mismatch),    0);
        check("midrst mole_pos",    int'(mole_pos),    0);
        rst = 1'b0;
        clear_counts();
        tick();
        tick();
        tick();
        check("postrst early pulse", c_mv, 0);
        tick();
        check("postrst mole_valid pulses", c_mv, 1);
        check("postrst mole_pos",   int'(mole_pos),   1);
        check("postrst moles_seen", int'(moles_seen), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg7_game_monitor
`default_nettype wire
